// File: rtl/count_mon_pkg.sv
// Shared definitions for the modulo-counter monitor: FSM states and the
// default sequence parameters agreed with the counter that drives the bus.
package count_mon_pkg;

  typedef enum logic [1:0] {
    CM_UNLOCKED,
    CM_ACQUIRE,
    CM_LOCKED
  } cm_state_e;

  localparam int CM_MOD    = 60;
  localparam int CM_LOCK_N = 4;
  localparam int CM_ERR_W  = 8;

endpackage

// File: rtl/count_mon_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [DATA_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {DATA_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/count_mon.sv
// Lock-and-track monitor for a modulo-MOD count stream with error, wrap and
// saturating statistics reporting.
module count_mon
  import count_mon_pkg::*;
#(
  parameter int WIDTH  = 6,
  parameter int MOD    = CM_MOD,
  parameter int LOCK_N = CM_LOCK_N,
  parameter int ERR_W  = CM_ERR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] count,
  input  logic             clr,
  output logic             locked,
  output logic [WIDTH-1:0] exp,
  output logic             err_pulse,
  output logic             wrap_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [ERR_W-1:0] wrap_cnt
);

  localparam int MW = $clog2(LOCK_N + 1);
  localparam logic [MW-1:0]    LOCK_M = MW'(LOCK_N);
  localparam logic [MW-1:0]    ONE_M  = MW'(1);
  localparam logic [WIDTH:0]   MOD_X  = (WIDTH + 1)'(MOD);
  localparam logic [WIDTH-1:0] LAST   = WIDTH'(MOD - 1);

  cm_state_e        state, state_nxt;
  logic [MW-1:0]    mcnt, mcnt_nxt;
  logic [WIDTH-1:0] exp_nxt;
  logic             err_nxt, wrap_nxt;
  logic             in_range;

  function automatic logic [WIDTH-1:0] next_val(input logic [WIDTH-1:0] v);
    return (v == LAST) ? '0 : v + 1'b1;
  endfunction

  // The modulus may equal 2^WIDTH, so the range compare is done one bit wider.
  assign in_range = ({1'b0, count} < MOD_X);

  always_comb begin
    state_nxt = state;
    mcnt_nxt  = mcnt;
    exp_nxt   = exp;
    err_nxt   = 1'b0;
    wrap_nxt  = 1'b0;
    if (en) begin
      case (state)
        CM_UNLOCKED: begin
          if (in_range) begin
            exp_nxt   = next_val(count);
            mcnt_nxt  = ONE_M;
            state_nxt = CM_ACQUIRE;
          end
        end
        CM_ACQUIRE: begin
          if (!in_range) begin
            mcnt_nxt  = '0;
            state_nxt = CM_UNLOCKED;
          end else if (count == exp) begin
            exp_nxt  = next_val(exp);
            mcnt_nxt = mcnt + 1'b1;
            if (mcnt_nxt == LOCK_M) state_nxt = CM_LOCKED;
          end else begin
            exp_nxt  = next_val(count);
            mcnt_nxt = ONE_M;
          end
        end
        CM_LOCKED: begin
          if (in_range && (count == exp)) begin
            exp_nxt  = next_val(exp);
            // A matched 0 while locked can only follow a MOD-1 sample.
            wrap_nxt = (count == '0);
          end else begin
            err_nxt = 1'b1;
            if (in_range) begin
              exp_nxt   = next_val(count);
              mcnt_nxt  = ONE_M;
              state_nxt = CM_ACQUIRE;
            end else begin
              mcnt_nxt  = '0;
              state_nxt = CM_UNLOCKED;
            end
          end
        end
        default: begin
          mcnt_nxt  = '0;
          state_nxt = CM_UNLOCKED;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= CM_UNLOCKED;
      mcnt       <= '0;
      exp        <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      mcnt       <= mcnt_nxt;
      exp        <= exp_nxt;
      locked     <= (state_nxt == CM_LOCKED);
      err_pulse  <= err_nxt;
      wrap_pulse <= wrap_nxt;
    end
  end

  sat_counter #(.DATA_W(ERR_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (err_nxt),
    .cnt (err_cnt)
  );

  sat_counter #(.DATA_W(ERR_W)) u_wrap_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (wrap_nxt),
    .cnt (wrap_cnt)
  );

endmodule

// File: tb/tb_count_mon.sv
// Bench for count_mon: directed scenarios with literal expectations plus a
// randomized run compared cycle by cycle against a streak-based model.
module tb_count_mon;

  localparam int WIDTH  = 6;
  localparam int MOD    = 60;
  localparam int LOCK_N = 4;
  localparam int ERR_W  = 8;
  localparam int SAT    = 255;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en  = 1'b0;
  logic             clr = 1'b0;
  logic [WIDTH-1:0] count = '0;
  logic             locked, err_pulse, wrap_pulse;
  logic [WIDTH-1:0] exp;
  logic [ERR_W-1:0] err_cnt, wrap_cnt;

  int errors = 0;
  int checks = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  count_mon #(.WIDTH(WIDTH), .MOD(MOD), .LOCK_N(LOCK_N), .ERR_W(ERR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .count      (count),
    .clr        (clr),
    .locked     (locked),
    .exp        (exp),
    .err_pulse  (err_pulse),
    .wrap_pulse (wrap_pulse),
    .err_cnt    (err_cnt),
    .wrap_cnt   (wrap_cnt)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int nxt(input int v);
    return (v == MOD - 1) ? 0 : v + 1;
  endfunction

  // Model: lock is a streak of successor samples; once locked, any
  // non-successor is an error that restarts the streak.
  bit m_locked = 0, m_err = 0, m_wrap = 0;
  int m_run = 0, m_last = 0, m_errc = 0, m_wrapc = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_locked = 0; m_err = 0; m_wrap = 0;
      m_run = 0; m_last = 0; m_errc = 0; m_wrapc = 0;
    end else begin
      int c;
      bit inr;
      m_err = 0;
      m_wrap = 0;
      if (en) begin
        c = int'(count);
        inr = (c < MOD);
        if (m_locked) begin
          if (inr && c == nxt(m_last)) begin
            m_wrap = (c == 0);
          end else begin
            m_err = 1;
            m_locked = 0;
            m_run = inr ? 1 : 0;
          end
        end else begin
          if (!inr) m_run = 0;
          else if (m_run > 0 && c == nxt(m_last)) m_run++;
          else m_run = 1;
          if (m_run >= LOCK_N) m_locked = 1;
        end
        m_last = c;
      end
      if (clr) m_errc = 0;
      else if (m_err && m_errc < SAT) m_errc++;
      if (clr) m_wrapc = 0;
      else if (m_wrap && m_wrapc < SAT) m_wrapc++;
    end
  end

  always @(negedge clk) begin
    if (cmp_on && rst) begin
      check("m_locked", locked, m_locked);
      check("m_err_pulse", err_pulse, m_err);
      check("m_wrap_pulse", wrap_pulse, m_wrap);
      check("m_err_cnt", err_cnt, m_errc);
      check("m_wrap_cnt", wrap_cnt, m_wrapc);
      if (m_locked || m_run > 0) check("m_exp", exp, nxt(m_last));
    end
  end

  task automatic step(input bit e, input int c, input bit cl);
    @(negedge clk);
    en = e;
    count = c[WIDTH-1:0];
    clr = cl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e, b, g, mode;
    repeat (2) @(posedge clk);
    #1;
    check("rst_locked", locked, 0);
    check("rst_exp", exp, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_wrap_pulse", wrap_pulse, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_wrap_cnt", wrap_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    cmp_on = 1'b1;

    // Lock from reset
    for (int v = 0; v < 3; v++) begin
      step(1, v, 0);
      check("lock_early", locked, 0);
    end
    step(1, 3, 0);
    check("lock_at_3", locked, 1);
    check("lock_err_cnt", err_cnt, 0);
    for (int v = 4; v <= 10; v++) step(1, v, 0);
    check("exp_after_10", exp, 11);

    // Sequence error and relock
    step(1, 11, 0);
    step(1, 13, 0);
    check("seq_err_pulse", err_pulse, 1);
    check("seq_err_cnt", err_cnt, 1);
    check("seq_unlocked", locked, 0);
    step(1, 14, 0);
    check("seq_pulse_once", err_pulse, 0);
    step(1, 15, 0);
    check("seq_not_yet", locked, 0);
    step(1, 16, 0);
    check("seq_relock", locked, 1);

    // Wrap
    for (int v = 17; v < MOD; v++) step(1, v, 0);
    step(1, 0, 0);
    check("wrap_pulse", wrap_pulse, 1);
    check("wrap_cnt", wrap_cnt, 1);
    step(1, 1, 0);
    check("wrap_pulse_once", wrap_pulse, 0);
    check("wrap_exp", exp, 2);

    // Out-of-range while locked, then repeated
    step(1, 62, 0);
    check("oor_err_pulse", err_pulse, 1);
    check("oor_err_cnt", err_cnt, 2);
    check("oor_unlocked", locked, 0);
    repeat (3) step(1, 62, 0);
    check("oor_no_more_pulse", err_pulse, 0);
    check("oor_no_more_cnt", err_cnt, 2);

    // en=0 ignores garbage
    for (int v = 5; v <= 8; v++) step(1, v, 0);
    check("en_locked", locked, 1);
    step(0, 33, 0);
    check("en0_locked", locked, 1);
    check("en0_exp", exp, 9);
    check("en0_err_cnt", err_cnt, 2);
    step(1, 9, 0);
    check("en1_resume", locked, 1);
    e = 10;

    // Saturation: 300 locked errors
    for (int i = 0; i < 300; i++) begin
      b = (e + 2) % MOD;
      step(1, b, 0);
      e = nxt(b);
      repeat (3) begin
        step(1, e, 0);
        e = nxt(e);
      end
    end
    check("sat_err_cnt", err_cnt, SAT);
    check("sat_locked", locked, 1);

    // clr wins over a simultaneous error
    b = (e + 2) % MOD;
    step(1, b, 1);
    check("clr_err_pulse", err_pulse, 1);
    check("clr_err_cnt", err_cnt, 0);
    e = nxt(b);

    // Build err_cnt=3, relock, then asynchronous reset between edges
    for (int k = 0; k < 3; k++) begin
      repeat (3) begin
        step(1, e, 0);
        e = nxt(e);
      end
      b = (e + 2) % MOD;
      step(1, b, 0);
      e = nxt(b);
    end
    check("pre_rst_err_cnt", err_cnt, 3);
    repeat (3) begin
      step(1, e, 0);
      e = nxt(e);
    end
    check("pre_rst_locked", locked, 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_locked", locked, 0);
    check("arst_exp", exp, 0);
    check("arst_err_pulse", err_pulse, 0);
    check("arst_wrap_pulse", wrap_pulse, 0);
    check("arst_err_cnt", err_cnt, 0);
    check("arst_wrap_cnt", wrap_cnt, 0);
    #1 rst = 1'b1;

    // Randomized run against the model
    g = $urandom_range(0, MOD - 1);
    for (int i = 0; i < 3000; i++) begin
      bit cl;
      mode = $urandom_range(0, 99);
      cl = ($urandom_range(0, 49) == 0);
      if (mode < 70) begin
        g = nxt(g);
        step(1, g, cl);
      end else if (mode < 77) begin
        g = $urandom_range(0, MOD - 1);
        step(1, g, cl);
      end else if (mode < 80) begin
        step(1, $urandom_range(MOD, 63), cl);
      end else if (mode < 85) begin
        step(1, g, cl);
      end else begin
        step(0, $urandom_range(0, 63), cl);
      end
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
